// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] lim);
        return (cur >= lim) ? lim : cur + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory side signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_if_req;
    logic [AW-1:0]   i_if_addr;
    logic            o_if_gnt;
    logic            o_if_rvalid;
    logic [DW-1:0]   o_if_rdata;

    logic            i_ls_req;
    logic            i_ls_we;
    logic [AW-1:0]   i_ls_addr;
    logic [DW-1:0]   i_ls_wdata;
    logic [DW/8-1:0] i_ls_bmask;
    logic            o_ls_gnt;
    logic            o_ls_rvalid;
    logic [DW-1:0]   o_ls_rdata;

    logic            o_mem_req;
    logic            o_mem_we;
    logic [AW-1:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_wdata;
    logic [DW/8-1:0] o_mem_bmask;
    logic            i_mem_ready;
    logic            i_mem_rvalid;
    logic [DW-1:0]   i_mem_rdata;

    // Arbiter view
    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata
    );

    // Core/memory environment view
    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - LS-priority pick rule with an IF anti-starvation streak limit
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_if_req,
    input  logic i_ls_req,
    input  logic i_fire,
    output logic o_pick_ls
);
    localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);

    logic [3:0] streak;

    assign o_pick_ls = i_ls_req & (~i_if_req | (streak < STREAK_LIM));

    // Streak only counts LS wins that actually made IF wait
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            streak <= 4'd0;
        end else if (i_fire) begin
            if (o_pick_ls && i_if_req) begin
                streak <= streak_inc(streak, STREAK_LIM);
            end else begin
                streak <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF and LS, one transaction in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_port_arbiter_if.slave bus,
    output logic              o_err
);
    arb_state_e      state;
    logic            owner;
    logic            mem_req_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] bmask_q;
    logic            if_rvalid_q;
    logic            ls_rvalid_q;
    logic [DW-1:0]   if_rdata_q;
    logic [DW-1:0]   ls_rdata_q;
    logic            err_q;
    logic            any_req;
    logic            fire;
    logic            pick_ls;

    assign any_req = bus.i_if_req | bus.i_ls_req;
    assign fire    = (state == ARB_IDLE) & any_req;

    mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_if_req  (bus.i_if_req),
        .i_ls_req  (bus.i_ls_req),
        .i_fire    (fire),
        .o_pick_ls (pick_ls)
    );

    assign bus.o_ls_gnt    = fire & pick_ls;
    assign bus.o_if_gnt    = fire & ~pick_ls;
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = we_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_bmask = bmask_q;
    assign bus.o_if_rvalid = if_rvalid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_ls_rvalid = ls_rvalid_q;
    assign bus.o_ls_rdata  = ls_rdata_q;
    assign o_err           = err_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ARB_IDLE;
            owner       <= OWNER_IF;
            mem_req_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bmask_q     <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            // A response is only legal once the request has been accepted
            if (bus.i_mem_rvalid && state != ARB_WAIT) begin
                err_q <= 1'b1;
            end
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        state     <= ARB_REQ;
                        mem_req_q <= 1'b1;
                        if (pick_ls) begin
                            owner   <= OWNER_LS;
                            we_q    <= bus.i_ls_we;
                            addr_q  <= bus.i_ls_addr;
                            wdata_q <= bus.i_ls_wdata;
                            bmask_q <= bus.i_ls_we ? bus.i_ls_bmask : '1;
                        end else begin
                            owner   <= OWNER_IF;
                            we_q    <= 1'b0;
                            addr_q  <= bus.i_if_addr;
                            wdata_q <= '0;
                            bmask_q <= '1;
                        end
                    end
                end
                ARB_REQ: begin
                    if (bus.i_mem_ready) begin
                        state     <= ARB_WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        state <= ARB_IDLE;
                        if (owner == OWNER_LS) begin
                            ls_rvalid_q <= 1'b1;
                            ls_rdata_q  <= we_q ? '0 : bus.i_mem_rdata;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus.i_mem_rdata;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench with reference memory and pick-rule model
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAXS)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          gap;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } req_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } memtx_t;

    req_t        if_todo[$];
    req_t        ls_todo[$];
    logic [31:0] if_exp[$];
    logic [31:0] ls_exp[$];
    memtx_t      mem_exp[$];
    logic        grant_log[$];
    logic [31:0] ref_mem[0:127];
    logic [31:0] dev_mem[0:127];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit in_flight = 0;
    int flight_age = 0;
    int streak = 0;
    int rdy_pct = 100;
    int dly_min = 1;
    int dly_max = 1;
    int resp_wait = 0;
    logic [31:0] resp_data = 32'd0;
    int if_gnt_cyc = 0;
    int mem_req_rise_cyc = 0;
    int if_rv_cyc = 0;
    logic [31:0] last_if_rdata = 32'd0;
    bit prev_mem_req = 0;
    int rv_unexpected = 0;
    bit accepted_flag = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] bm);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((if_todo.size() > 0 || ls_todo.size() > 0 || in_flight) && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, limit);
        end
    endtask

    // Requesters and memory device: drive just after the rising edge
    initial begin
        req_t t;
        bus.i_if_req = 0; bus.i_if_addr = 0;
        bus.i_ls_req = 0; bus.i_ls_we = 0; bus.i_ls_addr = 0; bus.i_ls_wdata = 0; bus.i_ls_bmask = 0;
        bus.i_mem_ready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.i_if_req = 0;
                bus.i_ls_req = 0;
            end else begin
                bus.i_if_req = 0;
                if (if_todo.size() > 0) begin
                    t = if_todo[0];
                    if (t.gap > 0) begin
                        t.gap--;
                        if_todo[0] = t;
                    end else begin
                        bus.i_if_req = 1;
                        bus.i_if_addr = t.addr;
                    end
                end
                bus.i_ls_req = 0;
                if (ls_todo.size() > 0) begin
                    t = ls_todo[0];
                    if (t.gap > 0) begin
                        t.gap--;
                        ls_todo[0] = t;
                    end else begin
                        bus.i_ls_req = 1;
                        bus.i_ls_we = t.we;
                        bus.i_ls_addr = t.addr;
                        bus.i_ls_wdata = t.wdata;
                        bus.i_ls_bmask = t.bmask;
                    end
                end
            end
            bus.i_mem_ready = ($urandom_range(0, 99) < rdy_pct);
            bus.i_mem_rvalid = 0;
            bus.i_mem_rdata = $urandom;
            if (resp_wait > 0) begin
                resp_wait--;
                if (resp_wait == 0) begin
                    bus.i_mem_rvalid = 1;
                    bus.i_mem_rdata = resp_data;
                end
            end
        end
    end

    // Monitor / scoreboard: sample on the falling edge
    initial begin
        req_t t;
        memtx_t m;
        logic [31:0] e;
        bit exp_ls;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_mem_req = 0;
            end else begin
                if (bus.o_if_rvalid) begin
                    if (if_exp.size() == 0) begin
                        checks++; failures++; rv_unexpected++;
                        $display("FAIL if_rvalid_unexpected: got 1 expected 0 at cycle %0d", cyc);
                    end else begin
                        e = if_exp.pop_front();
                        check("if_rdata", bus.o_if_rdata, e);
                        if_rv_cyc = cyc;
                        last_if_rdata = bus.o_if_rdata;
                    end
                    in_flight = 0;
                end
                if (bus.o_ls_rvalid) begin
                    if (ls_exp.size() == 0) begin
                        checks++; failures++; rv_unexpected++;
                        $display("FAIL ls_rvalid_unexpected: got 1 expected 0 at cycle %0d", cyc);
                    end else begin
                        e = ls_exp.pop_front();
                        check("ls_rdata", bus.o_ls_rdata, e);
                    end
                    in_flight = 0;
                end

                if (!in_flight && (bus.i_if_req || bus.i_ls_req)) begin
                    exp_ls = bus.i_ls_req && (!bus.i_if_req || streak < MAXS);
                    check("ls_gnt", 32'(bus.o_ls_gnt), 32'(exp_ls));
                    check("if_gnt", 32'(bus.o_if_gnt), 32'(!exp_ls));
                    grant_log.push_back(bus.o_ls_gnt);
                    if (exp_ls) begin
                        streak = bus.i_if_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
                        t = ls_todo.pop_front();
                        if (t.we) begin
                            ls_exp.push_back(32'd0);
                            ref_mem[widx(t.addr)] = merge(ref_mem[widx(t.addr)], t.wdata, t.bmask);
                            mem_exp.push_back('{1'b1, t.addr, t.wdata, t.bmask});
                        end else begin
                            ls_exp.push_back(ref_mem[widx(t.addr)]);
                            mem_exp.push_back('{1'b0, t.addr, t.wdata, 4'hF});
                        end
                    end else begin
                        streak = 0;
                        t = if_todo.pop_front();
                        if_gnt_cyc = cyc;
                        if_exp.push_back(ref_mem[widx(t.addr)]);
                        mem_exp.push_back('{1'b0, t.addr, 32'd0, 4'hF});
                    end
                    in_flight = 1;
                    flight_age = 0;
                end else begin
                    check("no_gnt", 32'({bus.o_if_gnt, bus.o_ls_gnt}), 32'd0);
                end

                if (bus.o_mem_req) begin
                    if (!prev_mem_req) mem_req_rise_cyc = cyc;
                    if (mem_exp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL mem_req_unexpected: got 1 expected 0 at cycle %0d", cyc);
                    end else begin
                        m = mem_exp[0];
                        check("mem_we", 32'(bus.o_mem_we), 32'(m.we));
                        check("mem_addr", bus.o_mem_addr, m.addr);
                        check("mem_wdata", bus.o_mem_wdata, m.wdata);
                        check("mem_bmask", 32'(bus.o_mem_bmask), 32'(m.bmask));
                        if (bus.i_mem_ready) begin
                            void'(mem_exp.pop_front());
                            if (bus.o_mem_we) begin
                                dev_mem[widx(bus.o_mem_addr)] = merge(dev_mem[widx(bus.o_mem_addr)],
                                                                      bus.o_mem_wdata, bus.o_mem_bmask);
                                resp_data = $urandom;
                            end else begin
                                resp_data = dev_mem[widx(bus.o_mem_addr)];
                            end
                            resp_wait = $urandom_range(dly_min, dly_max);
                            accepted_flag = 1;
                        end
                    end
                end
                prev_mem_req = bus.o_mem_req;

                if (in_flight) begin
                    flight_age++;
                    if (flight_age > 300) begin
                        checks++; failures++;
                        $display("FAIL response_timeout: no rvalid within 300 cycles of grant");
                        in_flight = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [11:0] pat;
        logic [31:0] v;
        req_t r;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            dev_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_if_gnt", 32'(bus.o_if_gnt), 32'd0);
        check("rst_ls_gnt", 32'(bus.o_ls_gnt), 32'd0);
        check("rst_if_rvalid", 32'(bus.o_if_rvalid), 32'd0);
        check("rst_ls_rvalid", 32'(bus.o_ls_rvalid), 32'd0);
        check("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
        check("rst_mem_addr", bus.o_mem_addr, 32'd0);
        check("rst_mem_bmask", 32'(bus.o_mem_bmask), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Single IF fetch, immediate ready, one-cycle memory
        @(negedge clk); #1;
        ref_mem[4] = 32'hDEADBEEF;
        dev_mem[4] = 32'hDEADBEEF;
        if_todo.push_back('{0, 1'b0, 32'h10, 32'd0, 4'h0});
        wait_idle(50, "t1");
        check("t1_gnt_to_mem_req", 32'(mem_req_rise_cyc - if_gnt_cyc), 32'd1);
        check("t1_gnt_to_rvalid", 32'(if_rv_cyc - if_gnt_cyc), 32'd3);
        check("t1_rdata", last_if_rdata, 32'hDEADBEEF);

        // Simultaneous IF fetch and LS store
        grant_log.delete();
        if_todo.push_back('{0, 1'b0, 32'h20, 32'd0, 4'h0});
        ls_todo.push_back('{0, 1'b1, 32'h100, $urandom, 4'b0011});
        wait_idle(50, "t2");
        check("t2_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check("t2_first_ls", 32'(grant_log[0]), 32'd1);
            check("t2_second_if", 32'(grant_log[1]), 32'd0);
        end

        // Both held continuously: four LS grants then one IF
        grant_log.delete();
        for (int i = 0; i < 10; i++) ls_todo.push_back('{0, 1'b0, 32'($urandom_range(0, 127)) << 2, $urandom, 4'h0});
        for (int i = 0; i < 2; i++) if_todo.push_back('{0, 1'b0, 32'($urandom_range(0, 127)) << 2, 32'd0, 4'h0});
        wait_idle(200, "t3");
        pat = 12'b110111101111;
        check("t3_grants", 32'(grant_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < grant_log.size(); i++) check($sformatf("t3_order%0d", i), 32'(grant_log[i]), 32'(pat[i]));

        // Memory stalls: request and fields held, no new grant
        rdy_pct = 0;
        r = '{0, 1'b1, 32'h1A4, $urandom, 4'b1001};
        ls_todo.push_back(r);
        if_todo.push_back('{0, 1'b0, 32'h44, 32'd0, 4'h0});
        for (int n = 0; n < 20 && !bus.o_mem_req; n++) begin
            @(negedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("t4_mem_req_held", 32'(bus.o_mem_req), 32'd1);
            check("t4_addr_held", bus.o_mem_addr, r.addr);
            check("t4_wdata_held", bus.o_mem_wdata, r.wdata);
            check("t4_no_if_gnt", 32'(bus.o_if_gnt), 32'd0);
            @(negedge clk); #1;
        end
        rdy_pct = 100;
        wait_idle(100, "t4");

        // Randomized traffic
        rdy_pct = 60;
        dly_min = 1;
        dly_max = 4;
        for (int i = 0; i < 40; i++) begin
            if_todo.push_back('{$urandom_range(0, 3), 1'b0, 32'($urandom_range(0, 127)) << 2, 32'd0, 4'h0});
            ls_todo.push_back('{$urandom_range(0, 4), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)) << 2,
                                $urandom, 4'($urandom_range(1, 15))});
        end
        wait_idle(3000, "t5");
        check("t5_err_clear", 32'(err), 32'd0);

        // Reset while waiting for a response; the response arrives after release
        rdy_pct = 100;
        dly_min = 6;
        dly_max = 6;
        accepted_flag = 0;
        if_todo.push_back('{0, 1'b0, 32'h80, 32'd0, 4'h0});
        for (int n = 0; n < 20 && !accepted_flag; n++) begin
            @(negedge clk); #1;
        end
        check("t6_accepted", 32'(accepted_flag), 32'd1);
        @(posedge clk); #3;
        rst_n = 0;
        in_flight = 0;
        streak = 0;
        if_exp.delete();
        ls_exp.delete();
        mem_exp.delete();
        rv_unexpected = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        repeat (10) @(negedge clk);
        #1;
        check("t6_no_rvalid", 32'(rv_unexpected), 32'd0);
        check("t6_err_set", 32'(err), 32'd1);
        dly_min = 1;
        dly_max = 1;
        grant_log.delete();
        if_todo.push_back('{0, 1'b0, 32'h84, 32'd0, 4'h0});
        wait_idle(50, "t6");
        check("t6_idle_grant", 32'(grant_log.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
